// File: rtl/cordic_tanh_pkg.sv
// rtl/cordic_tanh_pkg.sv - constants, state encoding and helpers for the hyperbolic CORDIC core
package cordic_hyp_pkg;

  localparam int FRAC_BITS = 16;
  localparam int QUO_BITS  = FRAC_BITS + 1;

  // x/y carry extra fraction bits so per-step shift truncation stays below 1 LSB at the output
  localparam int GUARD = 8;
  localparam int XW    = 32 + GUARD;

  localparam logic signed [31:0]   X0         = 32'sd79135;
  localparam logic signed [31:0]   Z_MAX      = 32'sd73269;
  localparam logic signed [31:0]   Z_MIN      = -32'sd73269;
  localparam logic [4:0]           REPEAT_A   = 5'd4;
  localparam logic [4:0]           REPEAT_B   = 5'd13;
  localparam logic signed [XW-1:0] ROUND_HALF = XW'(1) <<< (GUARD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROT,
    ST_DIV,
    ST_DONE
  } state_e;

  function automatic logic signed [31:0] atanh_q16(input logic [4:0] idx);
    case (idx)
      5'd1:    return 32'sd35999;
      5'd2:    return 32'sd16739;
      5'd3:    return 32'sd8235;
      5'd4:    return 32'sd4101;
      5'd5:    return 32'sd2049;
      5'd6:    return 32'sd1024;
      5'd7:    return 32'sd512;
      5'd8:    return 32'sd256;
      5'd9:    return 32'sd128;
      5'd10:   return 32'sd64;
      5'd11:   return 32'sd32;
      5'd12:   return 32'sd16;
      5'd13:   return 32'sd8;
      5'd14:   return 32'sd4;
      5'd15:   return 32'sd2;
      5'd16:   return 32'sd1;
      default: return 32'sd0;
    endcase
  endfunction

  function automatic logic signed [31:0] round_guard(input logic signed [XW-1:0] v);
    return 32'((v + ROUND_HALF) >>> GUARD);
  endfunction

endpackage

// File: rtl/cordic_tanh_if.sv
// rtl/cordic_tanh_if.sv - request/response handshake bundle of the cordic_tanh core
interface cordic_tanh_if;

  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] z_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] cosh_out;
  logic signed [31:0] sinh_out;
  logic signed [31:0] tanh_out;
  logic               range_err;

  modport master (
    output in_valid, z_in, out_ready,
    input  in_ready, out_valid, cosh_out, sinh_out, tanh_out, range_err
  );

  modport slave (
    input  in_valid, z_in, out_ready,
    output in_ready, out_valid, cosh_out, sinh_out, tanh_out, range_err
  );

endinterface

// File: rtl/cordic_div_q16.sv
// rtl/cordic_div_q16.sv - sequential restoring divider, floor(dividend * 2^16 / divisor), one bit per cycle
module cordic_div_q16
  import cordic_hyp_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [31:0]         dividend_i,
  input  logic [31:0]         divisor_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [QUO_BITS-1:0] quotient_o
);

  logic [33:0]         rem_q, rem_d, rem_sub;
  logic [31:0]         dvs_q, dvs_d;
  logic [QUO_BITS-1:0] quo_q, quo_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ge;

  // The 16 implied zero fraction bits enter through the left shift; dividend < 2*divisor keeps rem bounded
  assign ge      = rem_q >= {2'b00, dvs_q};
  assign rem_sub = ge ? (rem_q - {2'b00, dvs_q}) : rem_q;

  always_comb begin
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i) begin
      rem_d  = {2'b00, dividend_i};
      dvs_d  = divisor_i;
      quo_d  = '0;
      cnt_d  = 5'(QUO_BITS);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = rem_sub << 1;
      quo_d = {quo_q[QUO_BITS-2:0], ge};
      cnt_d = cnt_q - 5'd1;
      if (cnt_q == 5'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/cordic_tanh.sv
// rtl/cordic_tanh.sv - iterative hyperbolic CORDIC (rotation mode) producing cosh, sinh and tanh of a Q16.16 angle
module cordic_tanh
  import cordic_hyp_pkg::*;
#(
  parameter int ITER = 16
)
(
  input  logic          clk,
  input  logic          rst,
  cordic_tanh_if.slave  io
);

  localparam logic [4:0]           LAST_IDX = 5'(ITER);
  localparam logic signed [XW-1:0] X0_INIT  = XW'(X0) <<< GUARD;

  state_e state_q, state_d;

  logic signed [XW-1:0] x_q, x_d, y_q, y_d, x_sh, y_sh;
  logic signed [31:0]   z_q, z_d, z_clamp, atanh_i;
  logic [4:0]           i_q, i_d;
  logic                 rep_q, rep_d;
  logic                 clamp_q, clamp_d, clamped;
  logic signed [31:0]   cosh_q, cosh_d, sinh_q, sinh_d, tanh_q, tanh_d;
  logic                 rerr_q, rerr_d;
  logic                 repeat_now, last_step, dir_pos;

  logic                 div_start, div_busy, div_done;
  logic [QUO_BITS-1:0]  div_quo;
  logic signed [31:0]   cosh_next, sinh_next, quo_ext;
  logic [31:0]          div_dividend, div_divisor;

  assign x_sh    = x_q >>> i_q;
  assign y_sh    = y_q >>> i_q;
  assign atanh_i = atanh_q16(i_q);
  assign dir_pos = ~z_q[31];

  // Indices 4 and 13 run twice; the second pass is marked by rep_q
  assign repeat_now = ((i_q == REPEAT_A) || (i_q == REPEAT_B)) && !rep_q;
  assign last_step  = (i_q == LAST_IDX) && !repeat_now;

  assign clamped = (io.z_in > Z_MAX) || (io.z_in < Z_MIN);
  assign z_clamp = (io.z_in > Z_MAX) ? Z_MAX : ((io.z_in < Z_MIN) ? Z_MIN : io.z_in);

  // Divider is started from the final step's next-state values so DIV begins on the following edge
  assign cosh_next    = round_guard(x_d);
  assign sinh_next    = round_guard(y_d);
  assign div_divisor  = cosh_next;
  assign div_dividend = sinh_next[31] ? -sinh_next : sinh_next;
  assign quo_ext      = {{(32-QUO_BITS){1'b0}}, div_quo};

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    i_d       = i_q;
    rep_d     = rep_q;
    clamp_d   = clamp_q;
    cosh_d    = cosh_q;
    sinh_d    = sinh_q;
    tanh_d    = tanh_q;
    rerr_d    = rerr_q;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (io.in_valid) begin
          x_d     = X0_INIT;
          y_d     = '0;
          z_d     = z_clamp;
          i_d     = 5'd1;
          rep_d   = 1'b0;
          clamp_d = clamped;
          state_d = ST_ROT;
        end
      end
      ST_ROT: begin
        if (dir_pos) begin
          x_d = x_q + y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atanh_i;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atanh_i;
        end
        if (repeat_now) begin
          rep_d = 1'b1;
        end else begin
          rep_d = 1'b0;
          i_d   = i_q + 5'd1;
        end
        if (last_step) begin
          div_start = 1'b1;
          state_d   = ST_DIV;
        end
      end
      ST_DIV: begin
        if (div_done && !div_busy) begin
          cosh_d  = cosh_next;
          sinh_d  = sinh_next;
          tanh_d  = y_q[XW-1] ? -quo_ext : quo_ext;
          rerr_d  = clamp_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (io.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= 5'd1;
      rep_q   <= 1'b0;
      clamp_q <= 1'b0;
      cosh_q  <= '0;
      sinh_q  <= '0;
      tanh_q  <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      rep_q   <= rep_d;
      clamp_q <= clamp_d;
      cosh_q  <= cosh_d;
      sinh_q  <= sinh_d;
      tanh_q  <= tanh_d;
      rerr_q  <= rerr_d;
    end
  end

  cordic_div_q16 u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .dividend_i (div_dividend),
    .divisor_i  (div_divisor),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  assign io.in_ready  = (state_q == ST_IDLE);
  assign io.out_valid = (state_q == ST_DONE);
  assign io.cosh_out  = cosh_q;
  assign io.sinh_out  = sinh_q;
  assign io.tanh_out  = tanh_q;
  assign io.range_err = rerr_q;

endmodule

// File: tb/tb_cordic_tanh.sv
// tb/tb_cordic_tanh.sv - directed scoreboard bench for cordic_tanh
module tb_cordic_tanh;

  typedef struct {
    int   c;
    int   s;
    int   t;
    int   tol;
    int   ttol;
    int   rerr;
    int   acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb[$];
  logic ov_prev = 1'b0;

  cordic_tanh_if io();

  cordic_tanh #(.ITER(16)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int expv, input int tol);
    total++;
    assert (((obs >= expv - tol) && (obs <= expv + tol)) === 1'b1)
    else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d tol %0d", tag, obs, expv, tol);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (io.out_valid && !ov_prev) begin
        chk("out_valid_expected", int'(sb.size() > 0), 1, 0);
        if (sb.size() > 0) chk("latency", cyc - sb[0].acc, 36, 0);
      end
      if (io.out_valid && io.out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("cosh", io.cosh_out, e.c, e.tol);
        chk("sinh", io.sinh_out, e.s, e.tol);
        chk("tanh", io.tanh_out, e.t, e.ttol);
        chk("range_err", int'(io.range_err), e.rerr, 0);
      end
    end
    ov_prev <= io.out_valid;
  end

  task automatic send(input int z, input int c, input int s, input int t,
                      input int tol, input int ttol, input int rerr);
    int   k;
    exp_t e;
    k = 0;
    while (!io.in_ready && k < 200) begin
      @(posedge clk); #2;
      k++;
    end
    chk("in_ready_before_send", int'(io.in_ready), 1, 0);
    io.in_valid = 1'b1;
    io.z_in     = z;
    @(posedge clk); #2;
    e.c = c; e.s = s; e.t = t; e.tol = tol; e.ttol = ttol; e.rerr = rerr; e.acc = cyc;
    sb.push_back(e);
    io.in_valid = 1'b0;
    io.z_in     = 32'sh7fff0000;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge clk); #2;
      k++;
    end
    chk("drain", sb.size(), 0, 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(io.in_ready), 1, 0);
    chk({tag, "_out_valid"}, int'(io.out_valid), 0, 0);
    chk({tag, "_cosh"}, io.cosh_out, 0, 0);
    chk({tag, "_sinh"}, io.sinh_out, 0, 0);
    chk({tag, "_tanh"}, io.tanh_out, 0, 0);
    chk({tag, "_range_err"}, int'(io.range_err), 0, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   k;
    int   seen;
    logic stable;
    int   snap_c, snap_s, snap_t, snap_r;

    rst          = 1'b1;
    io.in_valid  = 1'b0;
    io.z_in      = '0;
    io.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk_zero_outputs("reset");
    rst = 1'b0;

    send(0, 65536, 0, 0, 4, 4, 0);
    drain();
    send(32768, 73900, 34151, 30285, 4, 4, 0);
    drain();
    send(-65536, 101128, -77017, -49912, 4, 4, 0);
    drain();
    send(131072, 110941, 89515, 52879, 8, 8, 1);
    drain();
    send(-73269, 110941, -89515, -52879, 6, 8, 0);
    drain();
    send(73270, 110941, 89515, 52879, 6, 8, 1);
    drain();

    // stalled consumer: outputs hold, extra requests are ignored
    io.out_ready = 1'b0;
    send(32768, 73900, 34151, 30285, 4, 4, 0);
    k = 0;
    while (!io.out_valid && k < 100) begin
      @(posedge clk); #2;
      k++;
    end
    chk("stall_out_valid", int'(io.out_valid), 1, 0);
    snap_c = io.cosh_out;
    snap_s = io.sinh_out;
    snap_t = io.tanh_out;
    snap_r = int'(io.range_err);
    stable = 1'b1;
    for (int n = 0; n < 50; n++) begin
      io.in_valid = n[0];
      io.z_in     = 32'sd12345 + n;
      @(posedge clk); #2;
      stable = stable && io.out_valid && !io.in_ready &&
               (io.cosh_out == snap_c) && (io.sinh_out == snap_s) &&
               (io.tanh_out == snap_t) && (int'(io.range_err) == snap_r);
    end
    io.in_valid = 1'b0;
    chk("stall_stable", int'(stable), 1, 0);
    io.out_ready = 1'b1;
    chk("in_ready_low_at_handshake", int'(io.in_ready), 0, 0);
    @(posedge clk); #2;
    chk("in_ready_after_handshake", int'(io.in_ready), 1, 0);
    chk("out_valid_after_handshake", int'(io.out_valid), 0, 0);
    send(-65536, 101128, -77017, -49912, 4, 4, 0);
    drain();

    // reset in the middle of the rotation phase abandons the operation
    send(65536, 101128, 77017, 49912, 4, 4, 0);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    chk_zero_outputs("midrst");
    @(posedge clk); #2;
    chk_zero_outputs("midrst_hold");
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #2;
      if (io.out_valid) seen++;
    end
    chk("no_spurious_out_valid", seen, 0, 0);
    send(32768, 73900, 34151, 30285, 4, 4, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
